product_accumulator: RTL and testbench
======================================

Name: product_accumulator

Overview:
- Downstream stage of the registered parameterized multiplier.
- Sums a run-time programmable number of products into one wide result, saturating on overflow. Presents the sum on a valid/ready output with a one-entry holding register.
- The multiplier output has no valid. The instantiating level delays its operand-valid by one clk and drives that delayed strobe onto data_valid_i, aligned with the multiplier's data_o.

Parameters:
- SIGNED, 1, 1 = two's-complement products and accumulator; 0 = unsigned.
- DATA_WIDTH, 32, input product width (DATA_WIDTH_1 + DATA_WIDTH_2 of the multiplier).
- ACC_WIDTH, 40, accumulator/output width; must be >= DATA_WIDTH.
- CNT_WIDTH, 8, width of frame length and sample counter.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- clear_i, input, 1, synchronous frame abort.
- len_i, input, CNT_WIDTH, samples per frame, sampled on the first accepted sample of each frame.
- data_i, input, DATA_WIDTH, product from the multiplier.
- data_valid_i, input, 1, data_i valid.
- data_ready_o, output, 1, sample accepted when data_valid_i && data_ready_o.
- data_o, output, ACC_WIDTH, frame sum.
- sat_o, output, 1, frame saturated at least once; qualified by data_valid_o.
- data_valid_o, output, 1, result valid.
- data_ready_i, input, 1, consumer accepts result.

Behaviour:
- Reset (rst=1 at clk edge): acc=0, count=0, len_reg=0, sat_acc=0, data_o=0, sat_o=0, data_valid_o=0. rst overrides clear_i and all handshakes.
- data_ready_o = !data_valid_o || data_ready_i. This is a combinational path from data_ready_i; it is the only combinational input-to-output path.
- Input extension to ACC_WIDTH: sign-extend when SIGNED=1, zero-extend when SIGNED=0.
- Accept cycle, first sample (count==0): len_reg <= len_i. len_i==0 is treated as 1. Effective length L is the latched value; len_i changes mid-frame are ignored.
- Accept cycle, non-final sample (count != L-1): acc <= sat(acc + x); count <= count+1; sat_acc |= overflow.
- Accept cycle, final sample (count == L-1):
  - data_o <= sat(acc + x); sat_o <= sat_acc | overflow; data_valid_o <= 1.
  - acc, count, sat_acc <= 0.
- Latency: result valid one clk after the final sample's accept edge. Back-to-back frames run with no bubble while data_ready_i=1.
- Saturation:
  - Overflow is computed on an ACC_WIDTH+1 bit sum.
  - SIGNED=1: clamp to 2^(ACC_WIDTH-1)-1 or -2^(ACC_WIDTH-1).
  - SIGNED=0: clamp to 2^ACC_WIDTH-1.
  - Once saturated, later samples keep adding from the clamped value.
- Output handshake:
  - data_valid_o && data_ready_i: data_valid_o <= 0, unless a final sample is accepted in the same cycle. In that case the new result loads and data_valid_o stays 1.
  - data_o and sat_o are stable while data_valid_o=1 && data_ready_i=0.
- Backpressure: while the result is held (data_valid_o=1, data_ready_i=0), data_ready_o=0 and no samples are accepted, including non-final ones.
- clear_i=1: acc, count, sat_acc <= 0 and any accept in that cycle is discarded. A pending output (data_o/sat_o/data_valid_o) is unaffected.
- Reset mid-frame or with a pending output: everything discarded; no output produced.
- Counter never wraps, since L <= 2^CNT_WIDTH-1.

Test Plan:
- SIGNED=1, DATA_WIDTH=32, ACC_WIDTH=40, len_i=4, products 100, -30, 7, 1, data_ready_i=1 -> data_valid_o one clk after 4th accept, data_o=78, sat_o=0, pulse width 1.
- len_i=3, 6 continuous samples of 5, data_ready_i=1 -> two results of 15 on consecutive frame boundaries, no bubble in data_ready_o.
- ACC_WIDTH=32, DATA_WIDTH=32, len_i=3, samples 0x7FFFFFFF, 0x7FFFFFFF, -1 -> data_o=0x7FFFFFFE, sat_o=1. Next frame len 1, sample 2 -> data_o=2, sat_o=0.
- len_i=2, samples 10, 20, data_ready_i=0 for 5 clks -> data_o=30 held stable, data_ready_o=0, extra valid samples not accepted. Raise data_ready_i -> handshake completes, data_ready_o=1.
- len_i=4, assert clear_i after 2 samples, then 4 samples of 1 -> single result data_o=4. Also rst mid-frame -> all outputs 0, next frame correct.
- len_i=0, sample 9 -> data_o=9 after one sample. SIGNED=0, ACC_WIDTH=DATA_WIDTH=8, len 2, samples 200, 100 -> data_o=255, sat_o=1.

Source files
------------

// File: rtl/product_accumulator.sv
// Frame accumulator behind the registered multiplier: sums a programmable number of
// products with saturation and hands each frame sum out through a one-entry valid/ready register.
module product_accumulator #(
  parameter int SIGNED     = 1,
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 40,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_i,
  input  logic [CNT_WIDTH-1:0]  len_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  data_valid_i,
  output logic                  data_ready_o,
  output logic [ACC_WIDTH-1:0]  data_o,
  output logic                  sat_o,
  output logic                  data_valid_o,
  input  logic                  data_ready_i
);

  localparam logic [ACC_WIDTH-1:0] MAX_S = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] MIN_S = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic [ACC_WIDTH-1:0] MAX_U = {ACC_WIDTH{1'b1}};

  // Returns {overflow, clamped sum}; the extra sum bit exposes overflow in both modes.
  function automatic logic [ACC_WIDTH:0] sat_add(input logic [ACC_WIDTH-1:0] a,
                                                 input logic [ACC_WIDTH-1:0] b);
    logic signed [ACC_WIDTH:0] s_sum;
    logic        [ACC_WIDTH:0] u_sum;
    logic        [ACC_WIDTH:0] res;
    s_sum = $signed({a[ACC_WIDTH-1], a}) + $signed({b[ACC_WIDTH-1], b});
    u_sum = {1'b0, a} + {1'b0, b};
    if (SIGNED != 0) begin
      if (s_sum[ACC_WIDTH] != s_sum[ACC_WIDTH-1])
        res = {1'b1, (s_sum[ACC_WIDTH] ? MIN_S : MAX_S)};
      else
        res = {1'b0, s_sum[ACC_WIDTH-1:0]};
    end else begin
      if (u_sum[ACC_WIDTH])
        res = {1'b1, MAX_U};
      else
        res = {1'b0, u_sum[ACC_WIDTH-1:0]};
    end
    return res;
  endfunction

  logic [ACC_WIDTH-1:0] acc;
  logic [CNT_WIDTH-1:0] count;
  logic [CNT_WIDTH-1:0] len_reg;
  logic                 sat_acc;

  logic [ACC_WIDTH-1:0] x_ext;
  logic [ACC_WIDTH:0]   sum_res;
  logic [CNT_WIDTH-1:0] len_fix;
  logic [CNT_WIDTH-1:0] cur_len;
  logic                 last;
  logic                 accept;

  always_comb begin
    if (SIGNED != 0)
      x_ext = ACC_WIDTH'($signed(data_i));
    else
      x_ext = ACC_WIDTH'(data_i);
  end

  assign data_ready_o = !data_valid_o || data_ready_i;
  assign accept       = data_valid_i && data_ready_o && !clear_i;
  assign sum_res      = sat_add(acc, x_ext);

  // The frame length is only taken from len_i on a frame's first sample.
  assign len_fix = (len_i == '0) ? CNT_WIDTH'(1) : len_i;
  assign cur_len = (count == '0) ? len_fix : len_reg;
  assign last    = (count == cur_len - CNT_WIDTH'(1));

  // Accumulate stage -> output holding register
  always_ff @(posedge clk) begin
    if (rst) begin
      acc          <= '0;
      count        <= '0;
      len_reg      <= '0;
      sat_acc      <= 1'b0;
      data_o       <= '0;
      sat_o        <= 1'b0;
      data_valid_o <= 1'b0;
    end else begin
      if (data_valid_o && data_ready_i)
        data_valid_o <= 1'b0;
      if (clear_i) begin
        acc     <= '0;
        count   <= '0;
        sat_acc <= 1'b0;
      end else if (accept) begin
        if (count == '0)
          len_reg <= len_fix;
        if (last) begin
          data_o       <= sum_res[ACC_WIDTH-1:0];
          sat_o        <= sat_acc | sum_res[ACC_WIDTH];
          data_valid_o <= 1'b1;
          acc          <= '0;
          count        <= '0;
          sat_acc      <= 1'b0;
        end else begin
          acc     <= sum_res[ACC_WIDTH-1:0];
          count   <= count + CNT_WIDTH'(1);
          sat_acc <= sat_acc | sum_res[ACC_WIDTH];
        end
      end
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench for product_accumulator: three instances cover signed 32->40,
// signed 32->32 and unsigned 8->8 configurations.
module tb_product_accumulator;

  typedef struct packed {
    logic [39:0] data;
    logic        sat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] din  [3];
  logic [7:0]  len  [3];
  logic        vin  [3];
  logic        clr  [3];
  logic        rdy  [3];

  logic [39:0] out_a;
  logic [31:0] out_b;
  logic [7:0]  out_c;
  logic        sat_a, sat_b, sat_c;
  logic        vo_a, vo_b, vo_c;
  logic        ro_a, ro_b, ro_c;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  product_accumulator #(.SIGNED(1), .DATA_WIDTH(32), .ACC_WIDTH(40), .CNT_WIDTH(8)) dut_a (
    .clk(clk), .rst(rst), .clear_i(clr[0]), .len_i(len[0]), .data_i(din[0]),
    .data_valid_i(vin[0]), .data_ready_o(ro_a), .data_o(out_a), .sat_o(sat_a),
    .data_valid_o(vo_a), .data_ready_i(rdy[0]));

  product_accumulator #(.SIGNED(1), .DATA_WIDTH(32), .ACC_WIDTH(32), .CNT_WIDTH(8)) dut_b (
    .clk(clk), .rst(rst), .clear_i(clr[1]), .len_i(len[1]), .data_i(din[1]),
    .data_valid_i(vin[1]), .data_ready_o(ro_b), .data_o(out_b), .sat_o(sat_b),
    .data_valid_o(vo_b), .data_ready_i(rdy[1]));

  product_accumulator #(.SIGNED(0), .DATA_WIDTH(8), .ACC_WIDTH(8), .CNT_WIDTH(8)) dut_c (
    .clk(clk), .rst(rst), .clear_i(clr[2]), .len_i(len[2]), .data_i(din[2][7:0]),
    .data_valid_i(vin[2]), .data_ready_o(ro_c), .data_o(out_c), .sat_o(sat_c),
    .data_valid_o(vo_c), .data_ready_i(rdy[2]));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic get_ready(input int u);
    case (u)
      0:       return ro_a;
      1:       return ro_b;
      default: return ro_c;
    endcase
  endfunction

  task automatic push(input int u, input logic [39:0] d, input logic s);
    exp_t e;
    e.data = d;
    e.sat  = s;
    case (u)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic pop(input int u, input logic [39:0] d, input logic s);
    exp_t e;
    int   n;
    case (u)
      0:       n = q0.size();
      1:       n = q1.size();
      default: n = q2.size();
    endcase
    if (n == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_result dut%0d got %0h expected none", u, d);
    end else begin
      case (u)
        0:       e = q0.pop_front();
        1:       e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      check($sformatf("result_data_dut%0d", u), 64'(d), 64'(e.data));
      check($sformatf("result_sat_dut%0d", u), 64'(s), 64'(e.sat));
    end
  endtask

  // Results leave on a handshake; sample at the falling edge, before the transfer edge.
  always @(negedge clk) if (!rst && vo_a && rdy[0]) pop(0, out_a, sat_a);
  always @(negedge clk) if (!rst && vo_b && rdy[1]) pop(1, {8'b0, out_b}, sat_b);
  always @(negedge clk) if (!rst && vo_c && rdy[2]) pop(2, {32'b0, out_c}, sat_c);

  // Presents one sample and returns 1ns after the edge on which it was accepted.
  task automatic send(input int u, input logic [31:0] d, input logic [7:0] l);
    int   n;
    logic r;
    din[u] = d;
    len[u] = l;
    vin[u] = 1'b1;
    n = 0;
    forever begin
      r = get_ready(u);
      @(posedge clk);
      #1;
      if (r) break;
      n++;
      if (n > 50) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout dut%0d waited %0d cycles, required <= 50", u, n);
        break;
      end
    end
  endtask

  task automatic stop(input int u);
    vin[u] = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int c0;

  initial begin
    for (int i = 0; i < 3; i++) begin
      din[i] = '0; len[i] = '0; vin[i] = 1'b0; clr[i] = 1'b0; rdy[i] = 1'b1;
    end
    rst = 1'b1;
    wait_cycles(3);
    check("reset_valid_a", 64'(vo_a), 64'd0);
    check("reset_data_a", 64'(out_a), 64'd0);
    check("reset_sat_a", 64'(sat_a), 64'd0);
    check("reset_valid_b", 64'(vo_b), 64'd0);
    check("reset_valid_c", 64'(vo_c), 64'd0);
    rst = 1'b0;
    wait_cycles(1);

    // Basic signed frame, latency and single-cycle valid pulse
    push(0, 40'd78, 1'b0);
    send(0, 32'd100, 8'd4);
    send(0, -32'sd30, 8'd4);
    send(0, 32'd7, 8'd4);
    send(0, 32'd1, 8'd4);
    stop(0);
    check("t1_valid", 64'(vo_a), 64'd1);
    check("t1_data", 64'(out_a), 64'd78);
    wait_cycles(1);
    check("t1_pulse", 64'(vo_a), 64'd0);

    push(0, 40'hFF_FFFF_FFE2, 1'b0);
    send(0, -32'sd50, 8'd2);
    send(0, 32'd20, 8'd2);
    stop(0);
    wait_cycles(2);

    // Back-to-back frames with no bubble
    push(0, 40'd15, 1'b0);
    push(0, 40'd15, 1'b0);
    c0 = cyc;
    for (int i = 0; i < 6; i++) send(0, 32'd5, 8'd3);
    stop(0);
    check("t2_cycles", 64'(cyc - c0), 64'd6);
    wait_cycles(2);

    // Signed saturation at ACC_WIDTH == DATA_WIDTH
    push(1, 40'h00_7FFF_FFFE, 1'b1);
    send(1, 32'h7FFF_FFFF, 8'd3);
    send(1, 32'h7FFF_FFFF, 8'd3);
    send(1, 32'hFFFF_FFFF, 8'd3);
    push(1, 40'd2, 1'b0);
    send(1, 32'd2, 8'd1);
    push(1, 40'h00_8000_0000, 1'b1);
    send(1, 32'h8000_0000, 8'd2);
    send(1, 32'h8000_0000, 8'd2);
    stop(1);
    wait_cycles(2);

    // Backpressure holds the result and blocks all samples
    rdy[0] = 1'b0;
    push(0, 40'd30, 1'b0);
    send(0, 32'd10, 8'd2);
    send(0, 32'd20, 8'd2);
    din[0] = 32'd1000;
    vin[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_cycles(1);
      check($sformatf("t4_hold_data_%0d", i), 64'(out_a), 64'd30);
      check($sformatf("t4_ready_low_%0d", i), 64'(ro_a), 64'd0);
      check($sformatf("t4_hold_valid_%0d", i), 64'(vo_a), 64'd1);
    end
    stop(0);
    rdy[0] = 1'b1;
    #1;
    check("t4_ready_comb", 64'(ro_a), 64'd1);
    wait_cycles(1);
    check("t4_released", 64'(vo_a), 64'd0);
    push(0, 40'd3, 1'b0);
    send(0, 32'd3, 8'd1);
    stop(0);
    wait_cycles(2);

    // Clear mid-frame; a sample presented during clear is discarded
    send(0, 32'd1, 8'd4);
    send(0, 32'd1, 8'd4);
    din[0] = 32'd50;
    clr[0] = 1'b1;
    wait_cycles(1);
    clr[0] = 1'b0;
    stop(0);
    push(0, 40'd4, 1'b0);
    for (int i = 0; i < 4; i++) send(0, 32'd1, 8'd4);
    stop(0);
    wait_cycles(2);

    // Reset mid-frame and with a pending result
    send(0, 32'd7, 8'd4);
    stop(0);
    rdy[1] = 1'b0;
    send(1, 32'd5, 8'd1);
    stop(1);
    check("t6_pending_b", 64'(vo_b), 64'd1);
    rst = 1'b1;
    wait_cycles(1);
    rst = 1'b0;
    check("t6_rst_valid_a", 64'(vo_a), 64'd0);
    check("t6_rst_data_a", 64'(out_a), 64'd0);
    check("t6_rst_valid_b", 64'(vo_b), 64'd0);
    check("t6_rst_data_b", 64'(out_b), 64'd0);
    check("t6_rst_sat_b", 64'(sat_b), 64'd0);
    rdy[1] = 1'b1;
    push(0, 40'd7, 1'b0);
    send(0, 32'd3, 8'd2);
    send(0, 32'd4, 8'd2);
    stop(0);
    wait_cycles(2);

    // Zero length behaves as one
    push(0, 40'd9, 1'b0);
    send(0, 32'd9, 8'd0);
    stop(0);
    wait_cycles(2);

    // Unsigned 8-bit saturation and a non-saturating frame after it
    push(2, 40'd255, 1'b1);
    send(2, 32'd200, 8'd2);
    send(2, 32'd100, 8'd2);
    push(2, 40'd150, 1'b0);
    send(2, 32'd100, 8'd2);
    send(2, 32'd50, 8'd2);
    stop(2);
    wait_cycles(5);

    check("q0_drained", 64'(q0.size()), 64'd0);
    check("q1_drained", 64'(q1.size()), 64'd0);
    check("q2_drained", 64'(q2.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
